lifo_driver: RTL and testbench
==============================

# lifo_driver

Stream-to-stack sequencer that owns the write/read side of the team's 4-bit LIFO. It accepts a nibble stream on a valid/ready input and pushes each accepted nibble into the LIFO. On a segment end it pops the LIFO dry and emits the nibbles in reverse order on a valid/ready output. It sits between an upstream nibble source and downstream consumers that need reversed segments, and shares clk and rst with the LIFO it drives.

## Interface
- DW, 4: data width; must match the LIFO word width.
- DEPTH, 5: LIFO capacity in words; the maximum segment length.
- CW, $clog2(DEPTH+1): width of the internal occupancy counter.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high. The LIFO is reset by the same signal.
- in_data  in  DW  input nibble.
- in_valid  in  1  in_data is valid.
- in_last  in  1  the current nibble ends the segment.
- in_ready  out  1  the driver accepts in_data this cycle.
- out_data  out  DW  reversed nibble.
- out_valid  out  1  out_data is valid.
- out_last  out  1  marks the final nibble of a segment that ended with in_last.
- out_ready  in  1  the consumer accepts out_data.
- lifo_data  out  DW  push data to the LIFO.
- lifo_rw  out  1  0 = push, 1 = pop.
- lifo_en  out  1  qualifies lifo_rw; the LIFO ignores rw while en = 0.
- lifo_q  in  DW  LIFO pop data; registered, valid the cycle after the pop.
- lifo_full  in  1  LIFO full flag.
- lifo_empty  in  1  LIFO empty flag.
- err  out  1  sticky protocol error.

## Operation
- The FSM has four states: FILL, POP, CAP and EMIT.
- FILL
  - in_ready = (cnt < DEPTH) & !lifo_full.
  - An input accept (in_valid & in_ready) drives lifo_en=1, lifo_rw=0 and lifo_data=in_data combinationally. It also increments cnt and latches seg_last <= in_last.
  - The FSM goes to POP when the accept carries in_last, or when the accept brings cnt to DEPTH.
  - With cnt==0 and no input, the FSM stays in FILL.
- POP
  - Drives lifo_en=1, lifo_rw=1 for exactly one cycle and decrements cnt. Next state is CAP.
- CAP
  - lifo_q is valid this cycle. out_data <= lifo_q, out_valid <= 1 and out_last <= seg_last & (cnt==0). Next state is EMIT.
- EMIT
  - out_data and out_valid are held until out_ready.
  - On the handshake, out_valid <= 0. The next state is POP if cnt != 0, otherwise FILL (and seg_last is cleared).
- Strobe rules
  - lifo_en is 0 in CAP and EMIT.
  - in_ready is 0 outside FILL.
  - lifo_data is 0 when no push is in progress.
- A segment longer than DEPTH without in_last is split at DEPTH. Each DEPTH-long chunk is reversed independently, with out_last=0 on it.
- Error checks:
  - The err flag is set if lifo_empty=1 during a POP cycle.
  - The err flag is also set if lifo_full=1 while cnt==0 in FILL.
  - err stays set until rst; operation continues regardless.
- Arithmetic: cnt is unsigned CW bits and never exceeds DEPTH or goes below 0.

## Timing
- Reset values: in_ready=0 during rst and 1 in the first cycle after it. out_valid=0, out_last=0, out_data=0, lifo_en=0, lifo_rw=0, lifo_data=0, err=0. State is FILL, cnt=0, seg_last=0.
- An rst assertion in any state aborts the operation next edge with no further LIFO strobes. Partial segments are discarded because the LIFO resets with the driver.
- Push latency: data accepted on edge N is in the LIFO at edge N.
- Pop latency: a pop issued in cycle N (POP) gives lifo_q in cycle N+1 (CAP). out_valid rises at edge N+2.
- Drain throughput is 1 nibble per 3 cycles with out_ready held high. Each extra cycle of out_ready=0 adds one cycle.
- The first push of the next segment can occur in the cycle after the last EMIT handshake.
- A segment of L nibbles with out_ready=1 occupies L input cycles plus 3L drain cycles.

## Test plan
- Reset, then stream 1,2,3 with in_last on 3 and out_ready=1 -> out 3,2,1; out_last only on 1; the first out_valid comes 2 cycles after the first pop; err=0.
- Stream 5 nibbles A,B,C,D,E with in_last on E -> in_ready drops after E; out E,D,C,B,A with out_last on A; lifo_en never asserted while lifo_full=1.
- Stream 7 nibbles 0..6 with no in_last until 6 -> first out 4,3,2,1,0 with out_last=0; then 6,5 with out_last on 5.
- Hold out_ready=0 for 4 cycles in EMIT during a drain -> out_data stable and no lifo_en during the stall; order preserved afterwards.
- Assert rst in CAP mid-drain -> next cycle all outputs are at reset values and state is FILL; a fresh segment 9,8 then reverses to 8,9.
- Force lifo_empty=1 during a POP cycle -> err rises next edge and stays high until rst.

Source files
------------

// File: rtl/lifo_driver_if.sv
// rtl/lifo_driver_if.sv - stream-in, reversed-stream-out and LIFO strobe bundle for lifo_driver
interface lifo_driver_if #(
    parameter int DW = 4
) ();
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [DW-1:0] lifo_data;
    logic          lifo_rw;
    logic          lifo_en;
    logic [DW-1:0] lifo_q;
    logic          lifo_full;
    logic          lifo_empty;
    logic          err;

    modport master (
        input  in_data, in_valid, in_last, out_ready, lifo_q, lifo_full, lifo_empty,
        output in_ready, out_data, out_valid, out_last, lifo_data, lifo_rw, lifo_en, err
    );

    modport slave (
        output in_data, in_valid, in_last, out_ready, lifo_q, lifo_full, lifo_empty,
        input  in_ready, out_data, out_valid, out_last, lifo_data, lifo_rw, lifo_en, err
    );
endinterface

// File: rtl/lifo_driver.sv
// rtl/lifo_driver.sv - pushes a nibble stream into the LIFO and drains each segment reversed
module lifo_driver #(
    parameter int DW    = 4,
    parameter int DEPTH = 5,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    lifo_driver_if.master  bus
);
    typedef enum logic [1:0] {S_FILL, S_POP, S_CAP, S_EMIT} state_t;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_seg_last;
    logic [DW-1:0]   r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_err;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_handshake;
    logic            w_lifo_en;
    logic            w_lifo_rw;
    logic [DW-1:0]   w_lifo_data;

    // Strobes are gated by rst so an abort never leaks a push or pop into the LIFO.
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        w_lifo_en   = 1'b0;
        w_lifo_rw   = 1'b0;
        w_lifo_data = '0;
        case (r_state)
            S_FILL: begin
                w_in_ready = !rst && (r_cnt < C_DEPTH) && !bus.lifo_full;
                w_accept   = w_in_ready && bus.in_valid;
                if (w_accept) begin
                    w_lifo_en   = 1'b1;
                    w_lifo_data = bus.in_data;
                    if (bus.in_last || (r_cnt == C_DEPTH - C_ONE))
                        w_next = S_POP;
                end
            end
            S_POP: begin
                w_lifo_en = !rst;
                w_lifo_rw = !rst;
                w_next    = S_CAP;
            end
            S_CAP: begin
                w_next = S_EMIT;
            end
            S_EMIT: begin
                w_handshake = r_out_valid && bus.out_ready;
                if (w_handshake)
                    w_next = (r_cnt != '0) ? S_POP : S_FILL;
            end
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            r_seg_last  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt      <= r_cnt + C_ONE;
                r_seg_last <= bus.in_last;
            end
            if (r_state == S_POP && r_cnt != '0)
                r_cnt <= r_cnt - C_ONE;
            if (r_state == S_CAP) begin
                r_out_data  <= bus.lifo_q;
                r_out_valid <= 1'b1;
                r_out_last  <= r_seg_last && (r_cnt == '0);
            end
            if (w_handshake) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                if (r_cnt == '0)
                    r_seg_last <= 1'b0;
            end
            // Protocol violations are only flagged; the sequencer keeps running.
            if ((r_state == S_POP && bus.lifo_empty) ||
                (r_state == S_FILL && r_cnt == '0 && bus.lifo_full))
                r_err <= 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.lifo_en   = w_lifo_en;
    assign bus.lifo_rw   = w_lifo_rw;
    assign bus.lifo_data = w_lifo_data;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_lifo_driver.sv
// tb/tb_lifo_driver.sv - randomized and directed bench for lifo_driver against a stream-reversal model
module tb_lifo_driver;
    localparam int DW    = 4;
    localparam int DEPTH = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    lifo_driver_if #(.DW(DW)) bus ();

    lifo_driver #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural LIFO that the driver talks to; flags can be forced to inject errors.
    logic [DW-1:0] stk [0:DEPTH-1];
    int            sp = 0;
    logic          force_full  = 1'b0;
    logic          force_empty = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            sp         <= 0;
            bus.lifo_q <= '0;
        end else if (bus.lifo_en) begin
            if (!bus.lifo_rw && sp < DEPTH) begin
                stk[sp] <= bus.lifo_data;
                sp      <= sp + 1;
            end else if (bus.lifo_rw && sp > 0) begin
                bus.lifo_q <= stk[sp-1];
                sp         <= sp - 1;
            end
        end
    end

    assign bus.lifo_full  = (sp == DEPTH) || force_full;
    assign bus.lifo_empty = (sp == 0) || force_empty;

    // Reference model: accepted nibbles gather in q_buf; each segment/DEPTH chunk is reversed into q_exp.
    logic [DW-1:0] q_buf [$];
    logic [DW:0]   q_exp [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.lifo_en && !bus.lifo_rw)
                check("push_while_full", bus.lifo_full, 0);
            else
                check("lifo_data_idle", bus.lifo_data, 0);
            if (bus.in_valid && bus.in_ready) begin
                check("push_strobe", {bus.lifo_en, bus.lifo_rw, bus.lifo_data}, {1'b1, 1'b0, bus.in_data});
                q_buf.push_back(bus.in_data);
                if (bus.in_last || q_buf.size() == DEPTH) begin
                    for (int i = q_buf.size() - 1; i >= 0; i--)
                        q_exp.push_back({(bus.in_last && i == 0), q_buf[i]});
                    q_buf.delete();
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q_exp.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    logic [DW:0] e;
                    e = q_exp.pop_front();
                    check("out_data", bus.out_data, e[DW-1:0]);
                    check("out_last", bus.out_last, e[DW]);
                end
            end
        end
    end

    logic rdy_rand = 1'b0;
    logic rdy_val  = 1'b1;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic push_nib(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q_exp.size() != 0 || q_buf.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.lifo_en && bus.lifo_rw) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("pop_timeout", 0, 1);
        t = cyc;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        force_full   = 1'b0;
        force_empty  = 1'b0;
        q_buf.delete();
        q_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int t0, t1, n;
        logic [DW-1:0] held;
        logic [DW-1:0] seq_a [5];
        seq_a = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_outs", {bus.out_valid, bus.out_last, bus.out_data}, 0);
        check("rst_lifo", {bus.lifo_en, bus.lifo_rw, bus.lifo_data, bus.err}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // 1,2,3 reversed; out_valid two cycles after the first pop
        push_nib(4'd1, 1'b0);
        push_nib(4'd2, 1'b0);
        push_nib(4'd3, 1'b1);
        wait_pop(t0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        check("first_out_latency", t1 - t0, 2);
        wait_drain();
        check("err_clean", bus.err, 0);

        // full-depth segment
        for (int i = 0; i < 5; i++) push_nib(seq_a[i], i == 4);
        @(negedge clk);
        check("in_ready_after_full", bus.in_ready, 0);
        @(posedge clk);
        #1;
        wait_drain();

        // 7-nibble stream split at DEPTH
        for (int i = 0; i < 7; i++) push_nib(4'(i), i == 6);
        wait_drain();

        // output stall
        rdy_val = 1'b0;
        push_nib(4'd7, 1'b0);
        push_nib(4'd8, 1'b0);
        push_nib(4'd9, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = bus.out_data;
        check("stall_first", held, 9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_data", bus.out_data, held);
            check("stall_valid", bus.out_valid, 1);
            check("stall_no_en", bus.lifo_en, 0);
        end
        rdy_val = 1'b1;
        @(posedge clk);
        #1;
        wait_drain();

        // reset during CAP
        for (int i = 1; i <= 4; i++) push_nib(4'(i), i == 4);
        wait_pop(t0);
        wait_pop(t0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_buf.delete();
        q_exp.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_outs", {bus.out_valid, bus.out_last, bus.out_data}, 0);
        check("abort_lifo", {bus.lifo_en, bus.lifo_rw, bus.lifo_data, bus.err}, 0);
        check("abort_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        push_nib(4'd9, 1'b0);
        push_nib(4'd8, 1'b1);
        wait_drain();

        // empty flag during POP
        push_nib(4'd1, 1'b0);
        push_nib(4'd2, 1'b1);
        wait_pop(t0);
        force_empty = 1'b1;
        @(posedge clk);
        #1;
        force_empty = 1'b0;
        @(negedge clk);
        check("err_empty_rise", bus.err, 1);
        @(posedge clk);
        #1;
        wait_drain();
        check("err_sticky", bus.err, 1);
        do_reset();
        @(negedge clk);
        check("err_cleared", bus.err, 0);
        @(posedge clk);
        #1;

        // full flag while idle in FILL
        force_full = 1'b1;
        @(negedge clk);
        check("full_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        force_full = 1'b0;
        @(negedge clk);
        check("err_full_rise", bus.err, 1);
        @(posedge clk);
        #1;
        do_reset();

        // randomized segments with random gaps and back-pressure
        rdy_rand = 1'b1;
        for (int s = 0; s < 12; s++) begin
            int len;
            logic term;
            len  = $urandom_range(1, 9);
            term = (s == 11) || ($urandom_range(0, 3) != 0);
            for (int i = 0; i < len; i++) begin
                push_nib(4'($urandom), term && (i == len - 1));
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        wait_drain();
        rdy_rand = 1'b0;
        check("err_random", bus.err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
